// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes, default
// bit timing and a parity helper. Used by the receiver and the planned transmitter.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

    // Parity mode codes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // 25 MHz / 115200 baud = 217 clocks per bit
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    // Parity bit a transmitter would send for this word. Unused upper bits
    // must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic x;
        x = ^data;
        return (mode == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, one chain per bit.
// Reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_q;
            logic sync_q;

            // Metastability filter: two back-to-back flops per bit
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_q <= RESET_VAL;
                    sync_q <= RESET_VAL;
                end else begin
                    meta_q <= d_i[gi];
                    sync_q <= meta_q;
                end
            end

            assign q_o[gi] = sync_q;
        end
    endgenerate

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, mid-bit sampling with
// false-start rejection, optional parity, 1 or 2 stop bits, one-cycle
// data_valid strobe with per-word parity and framing error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk25MHz,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    // Reject unsupported configurations at elaboration time
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 || CLKS_PER_BIT < 8) begin : g_param_check
            $error("uart_rx_param: illegal parameter combination");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk25MHz),
        .rst_n(rst_n),
        .d_i  (uart_rx),
        .q_o  (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_mis_q, par_mis_d;
    logic                 frm_q, frm_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dv_q, dv_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 frm_now;

    // Next-state and output-load logic for the receive FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_mis_d = par_mis_q;
        frm_d     = frm_q;
        dout_d    = dout_q;
        dv_d      = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        frm_now   = frm_q | ~rx_s;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: glitch
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        idx_d     = '0;
                        par_mis_d = 1'b0;
                        frm_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    par_mis_d = rx_s ^ parity_bit(9'(shift_q), PARITY_MODE);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    frm_d = frm_now;
                    if (idx_q == LAST_STOP) begin
                        // Publish the word on the same edge as the final stop sample
                        dout_d  = shift_q;
                        perr_d  = par_mis_q;
                        ferr_d  = frm_now;
                        dv_d    = 1'b1;
                        state_d = frm_now ? BREAK_WAIT : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK_WAIT: begin
                // Hold off until the line idles so a break yields one word only
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk25MHz) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_mis_q <= 1'b0;
            frm_q     <= 1'b0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_mis_q <= par_mis_d;
            frm_q     <= frm_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 8E1, 7N2) at
// 16 clocks per bit, directed scenarios followed by random frames.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int C = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] rx;
    wire  [7:0] dout_a, dout_b;
    wire  [6:0] dout_c;
    wire  [2:0] dv, pe, fe, busy;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk25MHz(clk), .rst_n(rst_n), .uart_rx(rx[0]), .data_out(dout_a),
        .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(busy[0]));
    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
        .clk25MHz(clk), .rst_n(rst_n), .uart_rx(rx[1]), .data_out(dout_b),
        .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(busy[1]));
    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_c (
        .clk25MHz(clk), .rst_n(rst_n), .uart_rx(rx[2]), .data_out(dout_c),
        .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(busy[2]));

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       q0[$], q1[$], q2[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         last_cyc[3];
    int         prev_cyc[3];
    logic [8:0] model_dout[3];

    function automatic int dbits(input int i); return (i == 2) ? 7 : 8; endfunction
    function automatic int pmode(input int i); return (i == 1) ? PARITY_EVEN : PARITY_NONE; endfunction
    function automatic int sbits(input int i); return (i == 2) ? 2 : 1; endfunction

    function automatic logic [8:0] get_dout(input int i);
        case (i)
            0:       return {1'b0, dout_a};
            1:       return {1'b0, dout_b};
            default: return {2'b0, dout_c};
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic cmp(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h", name, i, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d; e.pe = p; e.fe = f;
        model_dout[i] = d;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe pops one expectation and compares it
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < 3; i++) begin
            if (dv[i] === 1'b1) begin
                have = 1'b0;
                case (i)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid inst%0d: got strobe with data 0x%0h, required none", i, get_dout(i));
                end else begin
                    cmp("data_out", i, 32'(get_dout(i)), 32'(e.d));
                    cmp("parity_err", i, 32'(pe[i]), 32'(e.pe));
                    cmp("frame_err", i, 32'(fe[i]), 32'(e.fe));
                    $display("inst%0d word 0x%0h perr=%0d ferr=%0d at cycle %0d", i, get_dout(i), pe[i], fe[i], cyc);
                end
                prev_cyc[i] = last_cyc[i];
                last_cyc[i] = cyc;
            end
        end
    end

    task automatic bitp(input int i, input logic b);
        rx[i] = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input bit bad_par,
                              input logic [1:0] stop_mask, input int gap, input bit hold_low);
        int         nb, pm, sb;
        logic [8:0] d;
        logic       correct, pbit, pe_e, fe_e;
        nb      = dbits(i);
        pm      = pmode(i);
        sb      = sbits(i);
        d       = data & ((9'h1 << nb) - 9'h1);
        correct = (pm == PARITY_EVEN) ? ^d : ~^d;
        pbit    = correct ^ bad_par;
        pe_e    = (pm != PARITY_NONE) && (pbit != correct);
        fe_e    = 1'b0;
        for (int s = 0; s < sb; s++) if (stop_mask[s]) fe_e = 1'b1;
        push(i, d, pe_e, fe_e);
        bitp(i, 1'b0);
        for (int k = 0; k < nb; k++) bitp(i, d[k]);
        if (pm != PARITY_NONE) bitp(i, pbit);
        for (int s = 0; s < sb; s++) bitp(i, ~stop_mask[s]);
        rx[i] = hold_low ? 1'b0 : 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int i);
        int t;
        exp_t e;
        t = 0;
        while (qsize(i) != 0 && t < 40 * C) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (qsize(i) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout inst%0d: got %0d words outstanding, required 0", i, qsize(i));
            while (qsize(i) != 0) begin
                case (i)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         i, sb, gap;
        logic [1:0] mask;
        logic [7:0] rstv;

        rst_n = 1'b0;
        rx    = 3'b111;
        for (int k = 0; k < 3; k++) begin
            model_dout[k] = '0;
            last_cyc[k]   = 0;
            prev_cyc[k]   = 0;
        end
        repeat (5) @(posedge clk);
        #1;
        cmp("reset_busy", 0, 32'(busy), 32'h0);
        cmp("reset_valid", 0, 32'(dv), 32'h0);
        cmp("reset_data_out", 0, 32'(dout_a), 32'h0);
        cmp("reset_parity_err", 0, 32'(pe), 32'h0);
        cmp("reset_frame_err", 0, 32'(fe), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 basic word
        send_frame(0, 9'h055, 1'b0, 2'b00, C, 1'b0);
        drain(0);
        cmp("busy_after_frame", 0, 32'(busy[0]), 32'h0);

        // Short low glitch must be rejected
        rx[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cmp("glitch_busy_high", 0, 32'(busy[0]), 32'h1);
        rx[0] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        cmp("glitch_busy_low", 0, 32'(busy[0]), 32'h0);
        repeat (2 * C) @(posedge clk);
        #1;
        cmp("glitch_data_kept", 0, 32'(dout_a), 32'(model_dout[0]));

        // Even parity: wrong then right parity bit
        send_frame(1, 9'h0A3, 1'b1, 2'b00, C, 1'b0);
        send_frame(1, 9'h0A3, 1'b0, 2'b00, C, 1'b0);
        drain(1);

        // Framing error followed by a long break, then a clean word
        send_frame(0, 9'h03C, 1'b0, 2'b01, 0, 1'b1);
        repeat (40 * C) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        send_frame(0, 9'h081, 1'b0, 2'b00, C, 1'b0);
        drain(0);

        // 7N2 back-to-back, no idle gap
        send_frame(2, 9'h000, 1'b0, 2'b00, 0, 1'b0);
        send_frame(2, 9'h07F, 1'b0, 2'b00, C, 1'b0);
        drain(2);
        cmp("back_to_back_spacing", 2, 32'(last_cyc[2] - prev_cyc[2]), 32'(10 * C));

        // Reset during data bit 3 of 0xF7; released while bit 4 (high) is on the line
        rstv = 8'hF7;
        bitp(0, 1'b0);
        for (int k = 0; k < 3; k++) bitp(0, rstv[k]);
        rx[0] = rstv[3];
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("midframe_reset_data_out", 0, 32'(dout_a), 32'h0);
        cmp("midframe_reset_valid", 0, 32'(dv[0]), 32'h0);
        cmp("midframe_reset_parity_err", 0, 32'(pe[0]), 32'h0);
        cmp("midframe_reset_frame_err", 0, 32'(fe[0]), 32'h0);
        cmp("midframe_reset_busy", 0, 32'(busy[0]), 32'h0);
        for (int k = 0; k < 3; k++) model_dout[k] = '0;
        repeat (C - 10) @(posedge clk);
        #1;
        rx[0] = rstv[4];
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (C - 4) @(posedge clk);
        #1;
        for (int k = 5; k < 8; k++) bitp(0, rstv[k]);
        bitp(0, 1'b1);
        repeat (2 * C) @(posedge clk);
        #1;
        send_frame(0, 9'h012, 1'b0, 2'b00, C, 1'b0);
        drain(0);

        // Random frames with occasional parity and stop-bit corruption
        for (int r = 0; r < 30; r++) begin
            i    = $urandom_range(0, 2);
            sb   = sbits(i);
            mask = 2'b00;
            if ($urandom_range(0, 5) == 0) mask = 2'(1 << $urandom_range(0, sb - 1));
            gap  = (mask != 2'b00) ? C + $urandom_range(0, 10) : $urandom_range(0, 12);
            send_frame(i, 9'($urandom), ($urandom_range(0, 3) == 0), mask, gap, 1'b0);
        end
        for (int k = 0; k < 3; k++) drain(k);
        repeat (4 * C) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the fixed 8N1 receiver in the Pong FPGA control path.
- Generalised in data width, parity mode and stop-bit count.
- Adds an input synchroniser, false-start rejection, a single-cycle data-valid strobe and per-byte parity/framing error flags.
- Sits between the board UART pin and the paddle/command decoder. Runs in the 25 MHz pixel/game clock domain.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (>= 8).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_MODE, 0, parity: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk25MHz  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- data_out  output  DATA_BITS  last received word; held until the next data_valid.
- data_valid  output  1  one-cycle strobe: data_out and the error flags are new.
- parity_err  output  1  parity mismatch on the last word; updated with data_valid.
- frame_err  output  1  a stop bit sampled low on the last word; updated with data_valid.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n = 0 at clock edge): the outputs and internal state take these values on the next edge:
  - data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - State = IDLE, synchroniser flops = 1.
- Reset mid-frame aborts the frame; no data_valid is produced.
- uart_rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- The bit counter is $clog2(CLKS_PER_BIT) bits wide. HALF = CLKS_PER_BIT/2 (floor).
- IDLE: when rx_s = 0, go to START with the counter cleared.
- START: count to HALF-1, then sample rx_s.
  - Sample = 1: glitch; return to IDLE with no outputs changed.
  - Sample = 0: go to DATA with counter = 0 and bit index = 0.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: one bit period later, sample the parity bit.
  - Even mode: expected bit = XOR of the data bits.
  - Odd mode: expected bit = the inverse of that.
  - Store the mismatch internally.
- STOP: sample STOP_BITS bits, one per bit period. Any sample of 0 sets the internal framing flag.
- On the edge after the last stop sample, all of the following happen together:
  - data_out is loaded from the shift register.
  - parity_err is loaded from the stored mismatch (always 0 when PARITY_MODE = 0).
  - frame_err is loaded from the framing flag.
  - data_valid = 1 for exactly one cycle.
- After a good frame, go to IDLE.
- After a framing error, go to BREAK_WAIT. The FSM stays there until rx_s = 1, then goes to IDLE. A line held low (break) therefore never yields repeated words.
- data_out is never cleared except by reset.
- Back-to-back frames: IDLE is re-entered in time to detect a start edge immediately after the last stop bit. No gap is required.
- Latency: data_valid rises 2 + HALF + (DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT + 1 cycles after uart_rx falls (±1 cycle for the synchroniser phase). P = 1 if parity is enabled, else 0.
- Illegal parameter values (DATA_BITS outside 5..9, STOP_BITS not 1 or 2, PARITY_MODE > 2) fail elaboration via a generate-time check.

Decomposition:
- Shared package/include uart_pkg holds:
  - State encodings IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants.
  - A default CLKS_PER_BIT for 25 MHz @ 115200.
  - The package is reused by the planned uart_tx_param.
- One sub-module: sync_2ff (2-flop synchroniser with parameterised reset value 1), reused for other async inputs.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
- 8N1, send 0x55 -> one data_valid pulse; data_out = 0x55; parity_err = 0; frame_err = 0; busy falls afterwards.
- Low glitch of 5 cycles on an idle line -> no data_valid; busy returns to 0 within 12 cycles; data_out unchanged.
- PARITY_MODE = 2, send 0xA3 with parity bit 1 (correct is 0) -> data_out = 0xA3 with parity_err = 1; then send 0xA3 with parity bit 0 -> parity_err = 0.
- 8N1, send 0x3C with stop bit 0, then hold the line low for 40 bit periods -> exactly one data_valid with frame_err = 1. Release the line high, send 0x81 -> data_out = 0x81, frame_err = 0.
- STOP_BITS = 2, DATA_BITS = 7, send 0x00 then 0x7F back-to-back with no idle gap -> two data_valid pulses, exactly 10*16 cycles apart, with data 0x00 then 0x7F.
- Assert rst_n = 0 during data bit 3 of a frame, release before the frame ends -> no data_valid for that frame; all outputs 0; the next clean 0x12 frame is received correctly.
